wishbone_lsu: RTL and testbench

WISHBONE_LSU -- requirements
Module: wishbone_lsu

---
 rtl/wishbone_lsu.sv | 204 ++++++++++++++++++++
 tb/tb_wishbone_lsu.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_lsu.sv
// wishbone_lsu: load/store unit that turns single CPU accesses into
// Wishbone classic bus cycles.
//
// Handshake: the CPU raises `request` with its access fields; they are
// sampled only in a cycle where busy=0. The unit then holds busy=1 until
// the access finishes, and pulses `done` for exactly one cycle. `misaligned`
// and `bus_error` qualify that pulse and are 0 whenever done=0. A request
// present in the done cycle is accepted straight away.
//
// Ports:
//   clock, reset            single clock, asynchronous active-high reset
//   request, write_enable   access strobe, 1=store / 0=load
//   size, unsigned_load     0=byte 1=half 2=word 3=double; zero/sign extend
//   address, write_data     byte address, right-aligned store data
//   busy, done, read_data   status, completion pulse, extended load result
//   misaligned, bus_error   completion qualifiers
//   wb_*                    Wishbone classic master side
//   debug_state             current FSM state
module wishbone_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       request,
  input  logic                       write_enable,
  input  logic [1:0]                 size,
  input  logic                       unsigned_load,
  input  logic [ADDRESS_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]      write_data,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_WIDTH-1:0]      read_data,
  output logic                       misaligned,
  output logic                       bus_error,
  output logic                       wb_cyc,
  output logic                       wb_stb,
  output logic                       wb_we,
  output logic [ADDRESS_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH-1:0]      wb_dat_o,
  output logic [DATA_WIDTH/8-1:0]    wb_sel,
  input  logic [DATA_WIDTH-1:0]      wb_dat_i,
  input  logic                       wb_ack,
  input  logic                       wb_err,
  output logic [1:0]                 debug_state
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CW    = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUS    = 2'd1,
    REJECT = 2'd2
  } state_t;

  state_t state;

  // Latched access attributes used when the slave answers.
  logic             we_q;
  logic [1:0]       size_q;
  logic             unsigned_q;
  logic [OFF_W-1:0] off_q;
  logic [CW-1:0]    cnt;

  assign busy        = (state != IDLE);
  assign debug_state = state;

  // ---------------- request decode ----------------
  logic             req_illegal;
  logic             req_misaligned;
  logic [3:0]       req_bytes;
  logic [NB-1:0]    sel_base;
  logic [DATA_WIDTH-1:0] wd_masked;
  logic [OFF_W-1:0] req_off;
  logic [NB-1:0]    req_sel;
  logic [DATA_WIDTH-1:0] req_dat;

  assign req_off = address[OFF_W-1:0];

  always_comb begin
    req_illegal    = (size == 2'd3) && (DATA_WIDTH == 32);
    req_misaligned = 1'b0;
    req_bytes      = 4'd1;
    case (size)
      2'd1: begin req_misaligned = address[0];      req_bytes = 4'd2; end
      2'd2: begin req_misaligned = |address[1:0];   req_bytes = 4'd4; end
      2'd3: begin req_misaligned = |address[2:0];   req_bytes = 4'd8; end
      default: begin req_misaligned = 1'b0;         req_bytes = 4'd1; end
    endcase
    // Lanes outside the access width are forced to zero before shifting.
    for (int b = 0; b < NB; b++) begin
      sel_base[b]        = (b < int'(req_bytes));
      wd_masked[8*b +: 8] = sel_base[b] ? write_data[8*b +: 8] : 8'h00;
    end
  end

  assign req_sel = sel_base << req_off;
  assign req_dat = wd_masked << {req_off, 3'b000};

  // ---------------- load extraction ----------------
  logic [DATA_WIDTH-1:0] ld_shift;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [6:0]            ld_bits;
  logic                  ld_sign;

  assign ld_shift = wb_dat_i >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    ld_bits = 7'd8;
      2'd1:    ld_bits = 7'd16;
      2'd2:    ld_bits = 7'd32;
      default: ld_bits = 7'd64;
    endcase
    ld_sign = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i == int'(ld_bits) - 1) ld_sign = ld_shift[i];
    end
    // Full-width accesses have no bits above ld_bits, so they pass through.
    ld_ext = ld_shift;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i >= int'(ld_bits)) ld_ext[i] = unsigned_q ? 1'b0 : ld_sign;
    end
  end

  // ---------------- timeout ----------------
  logic [CW-1:0] cnt_next;
  logic          timeout_hit;

  assign cnt_next    = cnt + CW'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_next == CW'(TIMEOUT_CYCLES));

  // ---------------- FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      read_data  <= '0;
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_we      <= 1'b0;
      wb_adr     <= '0;
      wb_dat_o   <= '0;
      wb_sel     <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      off_q      <= '0;
      cnt        <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            if (req_illegal || req_misaligned) begin
              state <= REJECT;
            end else begin
              state      <= BUS;
              we_q       <= write_enable;
              size_q     <= size;
              unsigned_q <= unsigned_load;
              off_q      <= req_off;
              cnt        <= '0;
              wb_cyc     <= 1'b1;
              wb_stb     <= 1'b1;
              wb_we      <= write_enable;
              wb_adr     <= {address[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
              wb_sel     <= req_sel;
              wb_dat_o   <= req_dat;
            end
          end
        end
        BUS: begin
          if (wb_ack || wb_err || timeout_hit) begin
            state  <= IDLE;
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            wb_we  <= 1'b0;
            done   <= 1'b1;
            // An error wins over a simultaneous ack; no ack at all means timeout.
            if (wb_err || !wb_ack) bus_error <= 1'b1;
            else if (!we_q)        read_data <= ld_ext;
          end else begin
            cnt <= cnt_next;
          end
        end
        REJECT: begin
          state      <= IDLE;
          done       <= 1'b1;
          misaligned <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_lsu.sv
module tb_wishbone_lsu;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 32-bit DUT signals
  logic        request, write_enable, unsigned_load;
  logic [1:0]  size;
  logic [31:0] address, write_data;
  logic        busy, done, misaligned, bus_error;
  logic [31:0] read_data;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err;
  logic [1:0]  debug_state;

  // 64-bit DUT signals
  logic        req64, we64, uns64;
  logic [1:0]  size64;
  logic [31:0] addr64;
  logic [63:0] wd64;
  logic        busy64, done64, mis64, berr64;
  logic [63:0] rd64;
  logic        cyc64, stb64, wbwe64;
  logic [31:0] adr64;
  logic [63:0] dato64, dati64;
  logic [7:0]  sel64;
  logic        ack64, err64;
  logic [1:0]  dbg64;

  wishbone_lsu #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clock(clk), .reset(rst), .request(request), .write_enable(write_enable),
    .size(size), .unsigned_load(unsigned_load), .address(address),
    .write_data(write_data), .busy(busy), .done(done), .read_data(read_data),
    .misaligned(misaligned), .bus_error(bus_error), .wb_cyc(wb_cyc),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_o(wb_dat_o),
    .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err),
    .debug_state(debug_state)
  );

  wishbone_lsu #(.DATA_WIDTH(64), .ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(4)) dut64 (
    .clock(clk), .reset(rst), .request(req64), .write_enable(we64),
    .size(size64), .unsigned_load(uns64), .address(addr64),
    .write_data(wd64), .busy(busy64), .done(done64), .read_data(rd64),
    .misaligned(mis64), .bus_error(berr64), .wb_cyc(cyc64),
    .wb_stb(stb64), .wb_we(wbwe64), .wb_adr(adr64), .wb_dat_o(dato64),
    .wb_sel(sel64), .wb_dat_i(dati64), .wb_ack(ack64), .wb_err(err64),
    .debug_state(dbg64)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected completion: {read_data, misaligned, bus_error}
  logic [33:0] exp_q[$];

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        we;
    logic [7:0]  len;   // 0 = cycle is cut short by reset, length unchecked
  } bus_t;
  bus_t bus_q[$];

  logic [31:0] rd_model;

  // Reference model: behaviour of one access from the access rules alone.
  function automatic void ref_model(
    input  logic we, input logic [1:0] sz, input logic uns,
    input  logic [31:0] addr, input logic [31:0] wd, input logic [31:0] di,
    input  int mode, inout logic [31:0] rd,
    output logic mis, output logic berr, output logic [3:0] sel, output logic [31:0] dat);
    int nbytes;
    int off;
    logic [63:0] mask;
    logic [63:0] v;
    nbytes = 1 << sz;
    off    = int'(addr % 4);
    mis    = (sz == 2'd3) || ((addr % nbytes) != 0);
    mask   = (64'd1 << (8 * nbytes)) - 64'd1;
    sel    = 4'(((1 << nbytes) - 1) << off);
    dat    = 32'(({32'd0, wd} & mask) << (8 * off));
    berr   = !mis && (mode != 0);
    if (!mis && mode == 0 && !we) begin
      v = ({32'd0, di} >> (8 * off)) & mask;
      if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
      rd = v[31:0];
    end
  endfunction

  // ---------------- driver ----------------
  // mode: 0=ack, 1=err, 2=ack+err, 3=no response (timeout)
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] di, input int mode, input int dly, input int gap);
    logic mis, berr;
    logic [3:0] sel;
    logic [31:0] dat;
    bus_t b;
    repeat (gap) begin @(posedge clk); #1; end
    request = 1'b1; write_enable = we; size = sz; unsigned_load = uns;
    address = addr; write_data = wd;
    ref_model(we, sz, uns, addr, wd, di, mode, rd_model, mis, berr, sel, dat);
    exp_q.push_back({rd_model, mis, berr});
    if (!mis) begin
      b.adr = addr & 32'hFFFF_FFFC; b.sel = sel; b.dat = dat; b.we = we;
      b.len = (mode == 3) ? 8'd4 : 8'(dly + 1);
      bus_q.push_back(b);
    end
    @(posedge clk); #1;
    if (mis) check("reject_no_cyc", wb_cyc, 1'b0);
    else     check("stb_latency", wb_stb, 1'b1);
    // Inputs are scrambled while busy; the unit must ignore them.
    request = 1'($urandom_range(0, 1)); address = $urandom; write_data = $urandom;
    size = 2'($urandom_range(0, 3)); write_enable = 1'($urandom_range(0, 1));
    unsigned_load = 1'($urandom_range(0, 1));
    if (mis) begin
      @(posedge clk); #1;
    end else if (mode == 3) begin
      repeat (4) begin @(posedge clk); #1; wb_dat_i = $urandom; end
    end else begin
      repeat (dly) begin @(posedge clk); #1; wb_dat_i = $urandom; end
      wb_dat_i = di; wb_ack = (mode != 1); wb_err = (mode != 0);
      @(posedge clk); #1;
      wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = $urandom;
    end
    request = 1'b0;
    @(negedge clk);
    check("done_latency", done, 1'b1);
  endtask

  // ---------------- completion monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          check("read_data", read_data, e[33:2]);
          check("misaligned", misaligned, e[1]);
          check("bus_error", bus_error, e[0]);
        end
      end else begin
        check("flags_without_done", {misaligned, bus_error}, 2'b00);
      end
    end
  end

  // ---------------- bus monitor ----------------
  bus_t cur;
  logic in_bus = 1'b0;
  int   stb_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_eq_stb", wb_cyc, wb_stb);
      if (wb_stb) begin
        if (!in_bus) begin
          if (bus_q.size() == 0) begin
            check("unexpected_stb", wb_stb, 1'b0);
            cur = '0;
          end else begin
            cur = bus_q.pop_front();
          end
          in_bus  = 1'b1;
          stb_cnt = 0;
        end
        stb_cnt++;
        check("wb_adr", wb_adr, cur.adr);
        check("wb_sel", wb_sel, cur.sel);
        check("wb_dat_o", wb_dat_o, cur.dat);
        check("wb_we", wb_we, cur.we);
      end else if (in_bus) begin
        in_bus = 1'b0;
        if (cur.len != 8'd0) check("stb_cycles", stb_cnt, cur.len);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic mis_t, berr_t;
    logic [3:0] sel_t;
    logic [31:0] dat_t, rd_tmp;
    bus_t b;
    logic [63:0] d64;

    rst = 1'b1;
    request = 0; write_enable = 0; size = 0; unsigned_load = 0;
    address = 0; write_data = 0; wb_dat_i = 0; wb_ack = 0; wb_err = 0;
    req64 = 0; we64 = 0; uns64 = 0; size64 = 0; addr64 = 0; wd64 = 0;
    dati64 = 0; ack64 = 0; err64 = 0;
    rd_model = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_flags", {misaligned, bus_error}, 2'b00);
    check("rst_wb_ctl", {wb_cyc, wb_stb, wb_we}, 3'b000);
    check("rst_wb_sel", wb_sel, 4'h0);
    check("rst_wb_adr", wb_adr, 32'h0);
    check("rst_wb_dat_o", wb_dat_o, 32'h0);
    check("rst_read_data", read_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    do_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1); // signed byte
    do_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1); // unsigned byte
    do_txn(1'b1, 2'd0, 1'b0, 32'h102, 32'h123456AB, 32'h0, 0, 1, 1); // store byte
    do_txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 0, 0, 1);       // misaligned word
    do_txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 0, 0, 1);       // double on 32-bit
    do_txn(1'b0, 2'd1, 1'b0, 32'h106, 32'h0, 32'hBEEF0000, 0, 0, 1); // signed half
    do_txn(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h11111111, 3, 0, 1); // timeout
    do_txn(1'b0, 2'd2, 1'b0, 32'h108, 32'h0, 32'h22222222, 2, 1, 1); // ack+err
    do_txn(1'b1, 2'd1, 1'b0, 32'h10A, 32'hCAFE5678, 32'h0, 1, 2, 1); // err on store
    // Back-to-back: next request presented in the done cycle
    do_txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h7654_3210, 0, 0, 1);
    do_txn(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 32'h8001_0000, 0, 0, 0);
    do_txn(1'b1, 2'd2, 1'b0, 32'h204, 32'hA5A5_5A5A, 32'h0, 0, 3, 0);

    // Reset in the middle of a bus cycle
    @(posedge clk); #1;
    request = 1'b1; write_enable = 1'b0; size = 2'd2; unsigned_load = 1'b0;
    address = 32'h300; write_data = 32'h0;
    rd_tmp = rd_model;
    ref_model(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 0, rd_tmp, mis_t, berr_t, sel_t, dat_t);
    b.adr = 32'h300; b.sel = sel_t; b.dat = dat_t; b.we = 1'b0; b.len = 8'd0;
    bus_q.push_back(b);
    @(posedge clk); #1;
    request = 1'b0;
    check("stb_before_reset", wb_stb, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_cyc", wb_cyc, 1'b0);
    check("async_rst_stb", wb_stb, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_read_data", read_data, 32'h0);
    rd_model = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_txn(1'b0, 2'd0, 1'b1, 32'h301, 32'h0, 32'h0000_C300, 0, 0, 1);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [1:0] sz;
      logic [31:0] addr;
      int r, mode;
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      r = $urandom_range(0, 9);
      mode = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
      do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
             $urandom, $urandom, mode, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // 64-bit instance: double load, signed upper word, misaligned double
    @(posedge clk); #1;
    req64 = 1'b1; we64 = 1'b0; size64 = 2'd3; uns64 = 1'b0; addr64 = 32'h8;
    @(posedge clk); #1;
    req64 = 1'b0;
    @(negedge clk);
    check("d64_stb", stb64, 1'b1);
    check("d64_sel", sel64, 8'hFF);
    check("d64_adr", adr64, 32'h8);
    d64 = {$urandom, $urandom};
    dati64 = d64; ack64 = 1'b1;
    @(posedge clk); #1;
    ack64 = 1'b0;
    @(negedge clk);
    check("d64_done", done64, 1'b1);
    check("d64_read_data", rd64, d64);

    @(posedge clk); #1;
    req64 = 1'b1; size64 = 2'd2; uns64 = 1'b0; addr64 = 32'hC;
    @(posedge clk); #1;
    req64 = 1'b0;
    @(negedge clk);
    check("w64_sel", sel64, 8'hF0);
    check("w64_adr", adr64, 32'h8);
    d64 = {1'b1, 31'($urandom), $urandom};
    dati64 = d64; ack64 = 1'b1;
    @(posedge clk); #1;
    ack64 = 1'b0;
    @(negedge clk);
    check("w64_done", done64, 1'b1);
    check("w64_read_data", rd64, {{32{d64[63]}}, d64[63:32]});

    @(posedge clk); #1;
    req64 = 1'b1; size64 = 2'd3; addr64 = 32'h4;
    @(posedge clk); #1;
    req64 = 1'b0;
    check("m64_no_cyc", cyc64, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("m64_done", done64, 1'b1);
    check("m64_misaligned", mis64, 1'b1);
    check("m64_read_data", rd64, {{32{d64[63]}}, d64[63:32]});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("resp_queue_drained", exp_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
